riscv_load_unit: RTL and testbench
==================================

# riscv_load_unit

Multi-cycle load unit for the RISC-V core: accepts one load (lb/lh/lw/lbu/lhu) from the datapath, reads word-aligned data from data memory over a req/ack handshake, and returns the extracted, sign- or zero-extended value with its destination register tag. It is the read-side counterpart of the store path into `data_mem`. It sits between the datapath's execute stage and the data memory port. Misaligned accesses that span two words are split into two word reads.

## Interface
- `ADDR_W`, 32, byte address width; data width is fixed at 32.
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ld_valid`  in  1  load request present
- `ld_ready`  out  1  unit idle, request accepted when `ld_valid && ld_ready`
- `ld_addr`  in  ADDR_W  byte address (rs1 + imm)
- `ld_funct3`  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others illegal
- `ld_rd`  in  5  destination register tag
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_W  word-aligned read address (bits [1:0] = 0)
- `mem_ack`  in  1  read data valid on `mem_rdata` this cycle
- `mem_rdata`  in  32  read word, little-endian
- `res_valid`  out  1  one-cycle result strobe
- `res_data`  out  32  extended load result
- `res_rd`  out  5  tag copied from `ld_rd`
- `res_err`  out  1  illegal funct3; `res_data` = 0

## Operation
- States: IDLE, RD0, RD1, RESP. `ld_ready` = 1 only in IDLE.
- Accept in IDLE: latch `off = ld_addr[1:0]`, `base = ld_addr & ~3`, funct3, rd. Legal → RD0. Illegal → RESP with `res_err` = 1, no memory access.
- Split flag: lh/lhu with `off` = 3, lw with `off` ≠ 0. Bytes never split.
- RD0: `mem_req` = 1, `mem_addr` = base. On `mem_ack`: store word w0; split → RD1, else → RESP.
- RD1: `mem_req` = 1, `mem_addr` = base + 4, wrapping mod 2^ADDR_W. On `mem_ack`: store w1 → RESP.
- RESP: `res_valid` = 1 for exactly one cycle, then → IDLE.
- Extraction: `v = {w1, w0} >> (8*off)`; w1 = 0 when not split. Byte = v[7:0], half = v[15:0], word = v[31:0]. lb/lh sign-extend bit 7/15; lbu/lhu zero-extend.
- `mem_ack` ignored while `mem_req` = 0.
- `ld_valid` outside IDLE is ignored; no queuing.

## Timing
- Reset values: state IDLE, `ld_ready` 1, `mem_req` 0, `mem_addr` 0, `res_valid` 0, `res_data` 0, `res_rd` 0, `res_err` 0.
- `mem_req` and `mem_addr` are registered. They assert the cycle after accept and hold stable until the cycle `mem_ack` is sampled high.
- Latency from accept edge to `res_valid`, with zero-wait memory (ack in the first req cycle):
  - aligned: 2 cycles
  - split: 3 cycles
  - illegal: 1 cycle
- Each cycle of `mem_ack` delay adds one cycle.
- `res_data`, `res_rd` and `res_err` hold their values until the next RESP.
- Next accept is possible in the cycle after RESP; there is no back-to-back accept in RESP.
- Reset asserted mid-transaction abandons it: outputs return to reset values asynchronously, and no `res_valid` is issued for the abandoned load.

## Structure
- Header `riscv/mem.vh`: funct3 load encodings (`LB`, `LH`, `LW`, `LBU`, `LHU`) and the state encoding. The store unit also uses this header.
- Sub-module `load_extend` (combinational): inputs {w1,w0}, off, funct3; output 32-bit result. It is instantiated once; the FSM and registers stay in `riscv_load_unit`.

## Test plan
- Memory word 5 = 0xdeadc0de. lw at addr 20, immediate ack → one `mem_req` at 0x14, `res_valid` 2 cycles after accept, `res_data` = 0xdeadc0de, `res_rd` echoed.
- Same memory:
  - lb at addr 23 → 0xffffffde
  - lbu at addr 23 → 0x000000de
  - lh at addr 22 → 0xffffdead
  - lhu at addr 22 → 0x0000dead
  - lb at addr 21 → 0xffffffc0
- Word 6 = 0xc001c0de. lw at addr 22 → two requests (0x14, then 0x18), `res_data` = 0xc0dedead, latency 3 cycles. lh at addr 23 → 0xffffdede.
- `mem_ack` delayed 3 cycles in RD0 → `mem_addr` stable throughout, `ld_ready` 0, latency 5 cycles, correct data. A spurious `mem_ack` while idle is ignored.
- funct3 = 011 → no `mem_req`, `res_valid` after 1 cycle with `res_err` = 1 and `res_data` = 0. The next legal lw completes normally.
- `rst` pulsed while in RD1 → `mem_req` and `res_valid` drop immediately, `ld_ready` = 1. A late `mem_ack` produces no result; a subsequent lw returns correct data.

Source files
------------

// File: rtl/riscv_load_unit_pkg.sv
// Shared load-path definitions: funct3 load encodings, FSM state encoding and
// small decode helpers used by the load unit and its extraction stage.
package riscv_load_unit_pkg;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRd0  = 2'b01,
      StRd1  = 2'b10,
      StResp = 2'b11
   } state_e;

   function automatic logic is_legal(input logic [2:0] funct3);
      return (funct3 == F3Lb) || (funct3 == F3Lh) || (funct3 == F3Lw) ||
             (funct3 == F3Lbu) || (funct3 == F3Lhu);
   endfunction

   // A load needs a second word when its bytes run past the end of the first.
   function automatic logic needs_split(input logic [2:0] funct3, input logic [1:0] off);
      logic split;
      split = 1'b0;
      if ((funct3 == F3Lh) || (funct3 == F3Lhu)) begin
         split = (off == 2'd3);
      end else if (funct3 == F3Lw) begin
         split = (off != 2'd0);
      end
      return split;
   endfunction

endpackage

// File: rtl/riscv_load_unit_if.sv
// Load request, data-memory read and result signals of the load unit.
// slave: the load unit itself; master: datapath + data memory side.
interface riscv_load_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [2:0]        ld_funct3;
   logic [4:0]        ld_rd;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   logic              res_valid;
   logic [31:0]       res_data;
   logic [4:0]        res_rd;
   logic              res_err;

   modport slave (
      input  ld_valid, ld_addr, ld_funct3, ld_rd, mem_ack, mem_rdata,
      output ld_ready, mem_req, mem_addr, res_valid, res_data, res_rd, res_err
   );

   modport master (
      output ld_valid, ld_addr, ld_funct3, ld_rd, mem_ack, mem_rdata,
      input  ld_ready, mem_req, mem_addr, res_valid, res_data, res_rd, res_err
   );
endinterface

// File: rtl/riscv_load_unit_load_extend.sv
// load_extend stage: selects the addressed byte/half/word from the two-word
// window {w1, w0} and sign- or zero-extends it. Illegal funct3 yields 0.
module riscv_load_unit_load_extend
   import riscv_load_unit_pkg::*;
(
   input  logic [63:0] words,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] v;

   // Byte-granular right shift of the little-endian window by the offset.
   always_comb begin
      v = words[{1'b0, off, 3'b000} +: 32];
   end

   // Width select and extension.
   always_comb begin
      result = 32'h0;
      unique case (funct3)
         F3Lb:    result = {{24{v[7]}}, v[7:0]};
         F3Lh:    result = {{16{v[15]}}, v[15:0]};
         F3Lw:    result = v;
         F3Lbu:   result = {24'h0, v[7:0]};
         F3Lhu:   result = {16'h0, v[15:0]};
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/riscv_load_unit.sv
// Multi-cycle load unit: accepts one load, reads one or two aligned words
// over a req/ack port, returns the extended value with its rd tag.
// ADDR_W must match the ADDR_W of the connected interface instance.
module riscv_load_unit
   import riscv_load_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input logic              clk,
   input logic              rst,
   riscv_load_unit_if.slave bus
);

   state_e            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;
   logic [31:0]       w0_q, w0_d;
   logic [31:0]       w1_q, w1_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              res_valid_q, res_valid_d;
   logic [31:0]       res_data_q, res_data_d;
   logic [4:0]        res_rd_q, res_rd_d;
   logic              res_err_q, res_err_d;

   logic [31:0]       ext_w0, ext_w1, ext_result;

   // Feed the extractor with the word arriving this cycle so the result can be
   // registered on the same edge that ends the read.
   always_comb begin
      ext_w0 = (state_q == StRd0) ? bus.mem_rdata : w0_q;
      ext_w1 = (state_q == StRd1) ? bus.mem_rdata : w1_q;
   end

   riscv_load_unit_load_extend u_load_extend (
      .words  ({ext_w1, ext_w0}),
      .off    (off_q),
      .funct3 (funct3_q),
      .result (ext_result)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      base_d      = base_q;
      funct3_d    = funct3_q;
      rd_d        = rd_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_err_d   = res_err_q;

      unique case (state_q)
         StIdle: begin
            if (bus.ld_valid) begin
               off_d    = bus.ld_addr[1:0];
               base_d   = {bus.ld_addr[ADDR_W-1:2], 2'b00};
               funct3_d = bus.ld_funct3;
               rd_d     = bus.ld_rd;
               w0_d     = 32'h0;
               w1_d     = 32'h0;  // non-split loads see zero above w0
               if (is_legal(bus.ld_funct3)) begin
                  state_d    = StRd0;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {bus.ld_addr[ADDR_W-1:2], 2'b00};
               end else begin
                  state_d     = StResp;
                  res_valid_d = 1'b1;
                  res_data_d  = 32'h0;
                  res_rd_d    = bus.ld_rd;
                  res_err_d   = 1'b1;
               end
            end
         end
         StRd0: begin
            if (bus.mem_ack) begin
               w0_d = bus.mem_rdata;
               if (needs_split(funct3_q, off_q)) begin
                  state_d    = StRd1;
                  mem_addr_d = base_q + ADDR_W'(4);  // wraps at the top of memory
               end else begin
                  state_d     = StResp;
                  mem_req_d   = 1'b0;
                  res_valid_d = 1'b1;
                  res_data_d  = ext_result;
                  res_rd_d    = rd_q;
                  res_err_d   = 1'b0;
               end
            end
         end
         StRd1: begin
            if (bus.mem_ack) begin
               w1_d        = bus.mem_rdata;
               state_d     = StResp;
               mem_req_d   = 1'b0;
               res_valid_d = 1'b1;
               res_data_d  = ext_result;
               res_rd_d    = rd_q;
               res_err_d   = 1'b0;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset abandons any load in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         off_q       <= 2'd0;
         base_q      <= '0;
         funct3_q    <= 3'd0;
         rd_q        <= 5'd0;
         w0_q        <= 32'h0;
         w1_q        <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= 32'h0;
         res_rd_q    <= 5'd0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         base_q      <= base_d;
         funct3_q    <= funct3_d;
         rd_q        <= rd_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_err_q   <= res_err_d;
      end
   end

   assign bus.ld_ready  = (state_q == StIdle);
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_rd    = res_rd_q;
   assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_riscv_load_unit.sv
// Scoreboard bench for riscv_load_unit: a word memory with programmable ack
// delay answers reads; expected results are queued at issue and compared
// when res_valid is seen.
module tb_riscv_load_unit;

   logic clk;
   logic rst;

   riscv_load_unit_if #(.ADDR_W(32)) bus ();

   riscv_load_unit #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] req_log[$];
   logic [31:0] mem[0:63];
   int          cyc;
   int          n_checks;
   int          n_errors;
   int          ack_delay;
   logic        spurious_ack;
   logic [31:0] last_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Data memory: acks each request after ack_delay waiting cycles.
   initial begin
      int          wait_cnt;
      logic [31:0] hold_addr;
      wait_cnt      = 0;
      hold_addr     = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && !rst) begin
            if (wait_cnt == 0) hold_addr = bus.mem_addr;
            else check("mem_addr_stable", bus.mem_addr, hold_addr);
            if (wait_cnt >= ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem[bus.mem_addr[7:2]];
               req_log.push_back(bus.mem_addr);
               wait_cnt      = 0;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = $urandom;
               wait_cnt++;
            end
         end else begin
            bus.mem_ack   = spurious_ack;
            bus.mem_rdata = $urandom;
            wait_cnt      = 0;
         end
      end
   end

   // Result monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.res_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_res", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("res_data", bus.res_data, e.data);
               check("res_rd", {27'd0, bus.res_rd}, {27'd0, e.rd});
               check("res_err", {31'd0, bus.res_err}, {31'd0, e.err});
               check("latency", 32'(cyc - e.acc), 32'(e.lat));
               last_data = e.data;
            end
         end
      end
   end

   task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                          input int exp_nreq, input logic [31:0] a0, input logic [31:0] a1,
                          input bit poke_busy);
      exp_t e;
      int   guard;
      req_log.delete();
      @(negedge clk);
      check("ld_ready_idle", {31'd0, bus.ld_ready}, 32'd1);
      check("res_hold", bus.res_data, last_data);
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = addr;
      bus.ld_funct3 = f3;
      bus.ld_rd     = rd;
      e.data = exp_data;
      e.rd   = rd;
      e.err  = exp_err;
      e.lat  = exp_lat;
      e.acc  = cyc;
      sb.push_back(e);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      if (poke_busy) begin
         // A request while busy must be dropped, not queued.
         @(negedge clk);
         check("ld_ready_busy", {31'd0, bus.ld_ready}, 32'd0);
         bus.ld_valid = 1'b1;
         bus.ld_rd    = 5'd31;
         @(negedge clk);
         bus.ld_valid = 1'b0;
      end
      guard = 0;
      while (sb.size() != 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         check("result_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      check("nreq", 32'(req_log.size()), 32'(exp_nreq));
      if (exp_nreq > 0 && req_log.size() > 0) check("req_addr0", req_log[0], a0);
      if (exp_nreq > 1 && req_log.size() > 1) check("req_addr1", req_log[1], a1);
   endtask

   initial begin
      int guard;
      n_checks      = 0;
      n_errors      = 0;
      ack_delay     = 0;
      spurious_ack  = 1'b0;
      last_data     = 32'h0;
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = 32'h0;
      bus.ld_funct3 = 3'b000;
      bus.ld_rd     = 5'd0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[5]  = 32'hdeadc0de;
      mem[6]  = 32'hc001c0de;
      mem[63] = 32'h11223344;
      mem[0]  = 32'h55667788;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("rst_res_data", bus.res_data, 32'h0);
      check("rst_res_rd", {27'd0, bus.res_rd}, 32'd0);
      check("rst_res_err", {31'd0, bus.res_err}, 32'd0);
      rst = 1'b0;

      // Aligned and in-word accesses, zero-wait memory.
      do_load(32'd20, 3'b010, 5'd7,  32'hdeadc0de, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);
      do_load(32'd23, 3'b000, 5'd8,  32'hffffffde, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);
      do_load(32'd23, 3'b100, 5'd9,  32'h000000de, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);
      do_load(32'd22, 3'b001, 5'd10, 32'hffffdead, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);
      do_load(32'd22, 3'b101, 5'd11, 32'h0000dead, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);
      do_load(32'd21, 3'b000, 5'd12, 32'hffffffc0, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);

      // Split accesses, including wrap past the top of the address space.
      do_load(32'd22, 3'b010, 5'd13, 32'hc0dedead, 1'b0, 3, 2, 32'h14, 32'h18, 1'b0);
      do_load(32'd23, 3'b001, 5'd14, 32'hffffdede, 1'b0, 3, 2, 32'h14, 32'h18, 1'b0);
      do_load(32'hfffffffe, 3'b010, 5'd15, 32'h77881122, 1'b0, 3, 2,
              32'hfffffffc, 32'h00000000, 1'b0);

      // Spurious ack while idle must do nothing.
      @(negedge clk);
      spurious_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
      spurious_ack = 1'b0;

      // Delayed ack in RD0, with an ignored request poked while busy.
      ack_delay = 3;
      do_load(32'd20, 3'b010, 5'd16, 32'hdeadc0de, 1'b0, 5, 1, 32'h14, 32'h0, 1'b1);
      ack_delay = 0;

      // Illegal funct3 values, then a normal load.
      do_load(32'd20, 3'b011, 5'd17, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 1'b0);
      do_load(32'd21, 3'b111, 5'd18, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, 1'b0);
      do_load(32'd20, 3'b010, 5'd19, 32'hdeadc0de, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);

      // Reset while waiting in RD1: nothing may come out of the abandoned load.
      ack_delay = 5;
      @(negedge clk);
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 32'd22;
      bus.ld_funct3 = 3'b010;
      bus.ld_rd     = 5'd20;
      @(negedge clk);
      bus.ld_valid = 1'b0;
      guard = 0;
      while (!(bus.mem_req && bus.mem_addr == 32'h18) && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("reached_rd1", {31'd0, bus.mem_req}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_async_res_valid", {31'd0, bus.res_valid}, 32'd0);
      check("rst_async_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      check("rst_async_res_data", bus.res_data, 32'h0);
      last_data = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      spurious_ack = 1'b1;
      repeat (2) @(negedge clk);
      spurious_ack = 1'b0;
      check("late_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
      ack_delay = 0;
      do_load(32'd20, 3'b010, 5'd21, 32'hdeadc0de, 1'b0, 2, 1, 32'h14, 32'h0, 1'b0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
